vga_gain_ctrl: RTL and testbench

// Gain-step sequencer for the 8-channel VGA front end. Holds per-channel

---
 rtl/vga_gain_ctrl_pkg.sv | 36 +++
 rtl/vga_gain_ctrl_if.sv | 27 ++
 rtl/vga_gain_ctrl_rr_pick.sv | 28 ++
 rtl/vga_gain_ctrl.sv | 144 ++++++++++++++
 tb/tb_vga_gain_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_gain_ctrl_pkg.sv
// Shared constants, types and helpers for the VGA gain-step sequencer.
// Channel count, gain width and phase lengths are fixed here for the whole block.
package vga_gain_ctrl_pkg;

   localparam int unsigned NCH        = 8;
   localparam int unsigned GW         = 6;
   localparam int unsigned CHW        = 3;
   localparam int unsigned INIT_GAIN  = 0;
   localparam int unsigned SETUP_CYC  = 2;
   localparam int unsigned STROBE_CYC = 4;
   localparam int unsigned HOLD_CYC   = 2;

   localparam int unsigned MAX_CYC =
      (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                               : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
   localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef logic [GW-1:0]    gain_t;
   typedef logic [CHW-1:0]   chan_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   // Gray sequence 00->01->11->10->00 seen by the VGA step pins
   function automatic logic [1:0] gray_next(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         2'b00:   n = 2'b01;
         2'b01:   n = 2'b11;
         2'b11:   n = 2'b10;
         default: n = 2'b00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_gain_ctrl_if.sv
// Control/VGA bus of the gain sequencer: register writes, AGC nudges,
// and the up/down/step pin outputs with status.
interface vga_gain_ctrl_if;

   logic                                                         cfg_valid;
   logic                                                         cfg_ready;
   logic [vga_gain_ctrl_pkg::CHW-1:0]                            cfg_chan;
   logic [vga_gain_ctrl_pkg::GW-1:0]                             cfg_gain;
   logic [vga_gain_ctrl_pkg::NCH-1:0]                            agc_up;
   logic [vga_gain_ctrl_pkg::NCH-1:0]                            agc_dn;
   logic [vga_gain_ctrl_pkg::NCH-1:0]                            up;
   logic [vga_gain_ctrl_pkg::NCH-1:0]                            down;
   logic [1:0]                                                   step;
   logic                                                         busy;
   logic [vga_gain_ctrl_pkg::NCH*vga_gain_ctrl_pkg::GW-1:0]      gain_cur;

   modport master (
      output cfg_valid, cfg_chan, cfg_gain, agc_up, agc_dn,
      input  cfg_ready, up, down, step, busy, gain_cur
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_gain, agc_up, agc_dn,
      output cfg_ready, up, down, step, busy, gain_cur
   );

endinterface

// File: rtl/vga_gain_ctrl_rr_pick.sv
// Round-robin finder: first pending channel at or after ptr_i, wrapping mod NCH.
module vga_gain_ctrl_rr_pick
   import vga_gain_ctrl_pkg::*;
(
   input  logic [NCH-1:0] pend_i,
   input  chan_t          ptr_i,
   output logic           valid_c_o,
   output chan_t          idx_c_o
);

   int pos;

   // Scan farthest offset first so the nearest pending channel wins last
   always_comb begin
      valid_c_o = 1'b0;
      idx_c_o   = '0;
      pos       = 0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         pos = int'(ptr_i) + i;
         if (pos >= int'(NCH)) pos = pos - int'(NCH);
         if (pend_i[pos]) begin
            valid_c_o = 1'b1;
            idx_c_o   = CHW'(pos);
         end
      end
   end

endmodule

// File: rtl/vga_gain_ctrl.sv
// Gain-step sequencer: tracks per-channel target/current codes and replays
// every difference to the VGA as single-LSB up/down moves framed by a Gray step.
module vga_gain_ctrl
   import vga_gain_ctrl_pkg::*;
(
   input  logic             clk_1M,
   input  logic             rst,
   vga_gain_ctrl_if.slave   bus
);

   localparam gain_t GAIN_MAX = '1;

   state_t                  state_q, state_d;
   cnt_t                    cnt_q, cnt_d;
   chan_t                   chan_q, chan_d;
   chan_t                   rr_q, rr_d;
   logic                    dir_q, dir_d;
   logic [NCH-1:0]          up_q, up_d;
   logic [NCH-1:0]          down_q, down_d;
   logic [1:0]              step_q, step_d;
   logic                    busy_q, busy_d;
   logic                    cfg_ready_q;
   logic [NCH-1:0][GW-1:0]  cur_q, cur_d;
   logic [NCH-1:0][GW-1:0]  tgt_q, tgt_d;
   logic [NCH-1:0]          pend_c;
   logic                    pick_valid_c;
   chan_t                   pick_idx_c;

   vga_gain_ctrl_rr_pick u_rr_pick (
      .pend_i    (pend_c),
      .ptr_i     (rr_q),
      .valid_c_o (pick_valid_c),
      .idx_c_o   (pick_idx_c)
   );

   // Target update: a register write beats an AGC nudge on the same channel
   always_comb begin
      tgt_d  = tgt_q;
      pend_c = '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         if (bus.cfg_valid && cfg_ready_q && (bus.cfg_chan == CHW'(ch)))
            tgt_d[ch] = bus.cfg_gain;
         else if (bus.agc_up[ch] && !bus.agc_dn[ch] && (tgt_q[ch] != GAIN_MAX))
            tgt_d[ch] = tgt_q[ch] + GW'(1);
         else if (bus.agc_dn[ch] && !bus.agc_up[ch] && (tgt_q[ch] != '0))
            tgt_d[ch] = tgt_q[ch] - GW'(1);
         pend_c[ch] = (cur_q[ch] != tgt_q[ch]);
      end
   end

   // Move sequencer; the latched direction holds even if the target changes mid-move
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chan_d  = chan_q;
      rr_d    = rr_q;
      dir_d   = dir_q;
      up_d    = up_q;
      down_d  = down_q;
      step_d  = step_q;
      cur_d   = cur_q;
      case (state_q)
         IDLE: begin
            if (pick_valid_c) begin
               state_d = SETUP;
               cnt_d   = '0;
               chan_d  = pick_idx_c;
               dir_d   = (tgt_q[pick_idx_c] > cur_q[pick_idx_c]);
               up_d    = dir_d ? (NCH'(1) << pick_idx_c) : '0;
               down_d  = dir_d ? '0 : (NCH'(1) << pick_idx_c);
            end
         end
         SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
               state_d = STROBE;
               cnt_d   = '0;
               step_d  = gray_next(step_q);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STROBE: begin
            if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               state_d       = IDLE;
               cnt_d         = '0;
               cur_d[chan_q] = dir_q ? (cur_q[chan_q] + GW'(1)) : (cur_q[chan_q] - GW'(1));
               rr_d          = (chan_q == CHW'(NCH - 1)) ? '0 : (chan_q + CHW'(1));
               up_d          = '0;
               down_d        = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || (cur_d != tgt_d);
   end

   always_ff @(posedge clk_1M or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         chan_q      <= '0;
         rr_q        <= '0;
         dir_q       <= 1'b0;
         up_q        <= '0;
         down_q      <= '0;
         step_q      <= 2'b00;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b0;
         cur_q       <= {NCH{GW'(INIT_GAIN)}};
         tgt_q       <= {NCH{GW'(INIT_GAIN)}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         chan_q      <= chan_d;
         rr_q        <= rr_d;
         dir_q       <= dir_d;
         up_q        <= up_d;
         down_q      <= down_d;
         step_q      <= step_d;
         busy_q      <= busy_d;
         cfg_ready_q <= 1'b1;
         cur_q       <= cur_d;
         tgt_q       <= tgt_d;
      end
   end

   assign bus.cfg_ready = cfg_ready_q;
   assign bus.up        = up_q;
   assign bus.down      = down_q;
   assign bus.step      = step_q;
   assign bus.busy      = busy_q;
   assign bus.gain_cur  = cur_q;

endmodule

// File: tb/tb_vga_gain_ctrl.sv
// Bench for vga_gain_ctrl: expected moves are queued as stimulus is driven and
// a pin monitor pops and checks each move as the sequencer replays it.
module tb_vga_gain_ctrl;
   import vga_gain_ctrl_pkg::*;

   typedef struct {
      int ch;
      bit dir;
      int code;
   } move_t;

   logic clk_1M = 1'b0;
   logic rst    = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   move_t sb[$];

   always #5 clk_1M = ~clk_1M;

   vga_gain_ctrl_if bus ();

   vga_gain_ctrl dut (
      .clk_1M (clk_1M),
      .rst    (rst),
      .bus    (bus)
   );

   function automatic logic [1:0] tb_gray(input logic [1:0] s);
      logic [1:0] r;
      case (s)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b11;
         2'b11:   r = 2'b10;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   function automatic int gain_of(input int ch);
      logic [NCH*GW-1:0] g;
      g = bus.gain_cur;
      return int'(g[ch*GW +: GW]);
   endfunction

   // Pin monitor: checks each move against the scoreboard
   bit             prev_act = 1'b0;
   bit             have_m   = 1'b0;
   logic [1:0]     prev_step = 2'b00;
   move_t          cur_m;
   int             nsteps;
   logic [NCH-1:0] exp_up, exp_dn;
   bit             act;

   always @(negedge clk_1M) begin
      if (rst) begin
         prev_act  = 1'b0;
         have_m    = 1'b0;
         prev_step = 2'b00;
      end else begin
         act = ((bus.up | bus.down) != '0);
         if (act) begin
            checks++;
            if ($countones({bus.up, bus.down}) != 1) begin
               failures++;
               $display("FAIL onehot: up=%b down=%b, required exactly one bit", bus.up, bus.down);
            end
         end
         if (act && !prev_act) begin
            checks++;
            nsteps = 0;
            if (sb.size() == 0) begin
               failures++;
               have_m = 1'b0;
               $display("FAIL unexpected_move: up=%b down=%b, required no move", bus.up, bus.down);
            end else begin
               cur_m  = sb.pop_front();
               have_m = 1'b1;
               exp_up = cur_m.dir ? (NCH'(1) << cur_m.ch) : '0;
               exp_dn = cur_m.dir ? '0 : (NCH'(1) << cur_m.ch);
               if (bus.up !== exp_up || bus.down !== exp_dn) begin
                  failures++;
                  $display("FAIL move_start: up=%b down=%b, required up=%b down=%b",
                           bus.up, bus.down, exp_up, exp_dn);
               end
            end
         end
         if (bus.step !== prev_step) begin
            checks++;
            nsteps++;
            if (bus.step !== tb_gray(prev_step)) begin
               failures++;
               $display("FAIL step_gray: step=%b after %b, required %b", bus.step, prev_step, tb_gray(prev_step));
            end
         end
         if (!act && prev_act && have_m) begin
            checks++;
            if (gain_of(cur_m.ch) != cur_m.code || nsteps != 1) begin
               failures++;
               $display("FAIL move_end: ch%0d code=%0d steps=%0d, required code=%0d steps=1",
                        cur_m.ch, gain_of(cur_m.ch), nsteps, cur_m.code);
            end
            have_m = 1'b0;
         end
         prev_act  = act;
         prev_step = bus.step;
      end
   end

   task automatic drive(input logic v, input int ch, input int g,
                        input logic [NCH-1:0] au, input logic [NCH-1:0] ad);
      @(negedge clk_1M);
      bus.cfg_valid = v;
      bus.cfg_chan  = CHW'(ch);
      bus.cfg_gain  = GW'(g);
      bus.agc_up    = au;
      bus.agc_dn    = ad;
      @(negedge clk_1M);
      bus.cfg_valid = 1'b0;
      bus.agc_up    = '0;
      bus.agc_dn    = '0;
   endtask

   task automatic push_moves(input int ch, input int from, input int to);
      if (to > from) for (int c = from + 1; c <= to; c++) sb.push_back('{ch, 1'b1, c});
      else           for (int c = from - 1; c >= to; c--) sb.push_back('{ch, 1'b0, c});
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk_1M);
         n++;
      end while ((bus.busy || sb.size() != 0) && n < budget);
      checks++;
      if (bus.busy || sb.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, required idle", name, bus.busy, sb.size(), n);
      end
   endtask

   task automatic quiet_window(input int ch, input int code, input string name);
      bit saw_busy = 1'b0;
      repeat (15) begin
         @(negedge clk_1M);
         if (bus.busy) saw_busy = 1'b1;
      end
      checks++;
      if (saw_busy || gain_of(ch) != code) begin
         failures++;
         $display("FAIL %s: busy_seen=%b ch%0d=%0d, required busy_seen=0 code=%0d", name, saw_busy, ch, gain_of(ch), code);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_1M);
      rst = 1'b1;
      sb.delete();
      repeat (2) @(negedge clk_1M);
      rst = 1'b0;
      repeat (2) @(negedge clk_1M);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_1M);
      checks++;
      if (bus.cfg_ready !== 1'b0 || bus.up !== '0 || bus.down !== '0 || bus.step !== 2'b00 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: ready=%b up=%b down=%b step=%b busy=%b, required all 0",
                  bus.cfg_ready, bus.up, bus.down, bus.step, bus.busy);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk_1M);
      checks++;
      if (bus.cfg_ready !== 1'b1 || bus.gain_cur !== {NCH{GW'(INIT_GAIN)}} || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: ready=%b gain_cur=%h busy=%b, required ready=1 gain_cur=0 busy=0",
                  bus.cfg_ready, bus.gain_cur, bus.busy);
      end
   endtask

   task automatic test_single_ch();
      push_moves(2, 0, 3);
      drive(1'b1, 2, 3, '0, '0);
      repeat (26) @(negedge clk_1M);
      checks++;
      if (bus.busy !== 1'b1 || gain_of(2) != 2) begin
         failures++;
         $display("FAIL single_last_hold: busy=%b ch2=%0d, required busy=1 ch2=2", bus.busy, gain_of(2));
      end
      @(negedge clk_1M);
      checks++;
      if (bus.busy !== 1'b0 || gain_of(2) != 3 || sb.size() != 0) begin
         failures++;
         $display("FAIL single_done: busy=%b ch2=%0d pending=%0d, required busy=0 ch2=3 pending=0",
                  bus.busy, gain_of(2), sb.size());
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      sb.push_back('{0, 1'b1, 1});
      sb.push_back('{5, 1'b1, 1});
      sb.push_back('{0, 1'b1, 2});
      sb.push_back('{5, 1'b1, 2});
      drive(1'b0, 0, 0, 8'h21, '0);
      drive(1'b0, 0, 0, 8'h21, '0);
      wait_idle(100, "rr");
   endtask

   task automatic test_saturate();
      push_moves(1, 0, 63);
      drive(1'b1, 1, 63, '0, '0);
      wait_idle(700, "sat_fill");
      drive(1'b0, 0, 0, 8'h02, '0);
      quiet_window(1, 63, "sat_top");
      push_moves(1, 63, 0);
      drive(1'b1, 1, 0, '0, '0);
      wait_idle(700, "sat_drain");
      drive(1'b0, 0, 0, '0, 8'h02);
      quiet_window(1, 0, "sat_bottom");
   endtask

   task automatic test_cfg_wins();
      push_moves(3, 0, 10);
      drive(1'b1, 3, 10, '0, 8'h08);
      wait_idle(200, "cfg_wins_dn");
      checks++;
      if (gain_of(3) != 10) begin
         failures++;
         $display("FAIL cfg_wins_dn: ch3=%0d, required 10", gain_of(3));
      end
      push_moves(3, 10, 5);
      drive(1'b1, 3, 5, 8'h08, '0);
      wait_idle(100, "cfg_wins_up");
      checks++;
      if (gain_of(3) != 5) begin
         failures++;
         $display("FAIL cfg_wins_up: ch3=%0d, required 5", gain_of(3));
      end
   endtask

   task automatic test_agc_both();
      push_moves(4, 0, 2);
      drive(1'b1, 4, 2, '0, '0);
      wait_idle(100, "both_setup");
      drive(1'b0, 0, 0, 8'h10, 8'h10);
      quiet_window(4, 2, "agc_both");
   endtask

   task automatic test_reset_mid_move();
      int n = 0;
      bit saw_busy = 1'b0;
      do_reset();
      push_moves(6, 0, 5);
      drive(1'b1, 6, 5, '0, '0);
      while (bus.step !== 2'b01 && n < 30) begin
         @(negedge clk_1M);
         n++;
      end
      checks++;
      if (bus.step !== 2'b01 || bus.up !== 8'h40) begin
         failures++;
         $display("FAIL mid_reach_strobe: step=%b up=%b, required step=01 up=01000000", bus.step, bus.up);
      end
      @(negedge clk_1M);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      checks++;
      if (bus.up !== '0 || bus.down !== '0 || bus.step !== 2'b00 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_abort: up=%b down=%b step=%b busy=%b ready=%b, required all 0",
                  bus.up, bus.down, bus.step, bus.busy, bus.cfg_ready);
      end
      repeat (3) @(negedge clk_1M);
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk_1M);
         if (bus.busy) saw_busy = 1'b1;
      end
      checks++;
      if (saw_busy || bus.gain_cur !== {NCH{GW'(INIT_GAIN)}} || bus.step !== 2'b00) begin
         failures++;
         $display("FAIL mid_after: busy_seen=%b gain_cur=%h step=%b, required busy_seen=0 gain_cur=0 step=00",
                  saw_busy, bus.gain_cur, bus.step);
      end
   endtask

   initial begin
      bus.cfg_valid = 1'b0;
      bus.cfg_chan  = '0;
      bus.cfg_gain  = '0;
      bus.agc_up    = '0;
      bus.agc_dn    = '0;
      test_reset();
      test_single_ch();
      test_round_robin();
      test_saturate();
      test_cfg_wins();
      test_agc_both();
      test_reset_mid_move();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
